// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: command/response codes, host transmitter FSM states,
// and a small elaboration-time helper.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INHIBIT   = 4'd1,
    ST_START     = 4'd2,
    ST_DATA      = 4'd3,
    ST_STOP      = 4'd4,
    ST_ACK       = 4'd5,
    ST_WAIT_IDLE = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } ps2_tx_state_e;

  function automatic int ps2_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILTER_LEN-sample glitch filter
// and a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          fall_reg;

  // Idle bus is pulled high, so everything resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], line};
      fall_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        fall_reg  <= ~sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits + odd parity
// + stop clocked by the device, then ACK check. Lines are open-drain (0 or Z).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA
);

  localparam int TMAX = ps2_max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] INH_DATA   = TW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);

  ps2_tx_state_e state_reg;
  logic [8:0]    shift_reg;
  logic [3:0]    bit_cnt_reg;
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_next;
  logic          clk_oe_reg;
  logic          data_oe_reg;
  logic [1:0]    data_sync_reg;
  logic          clk_level;
  logic          clk_fall;
  logic          data_sync;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .line  (PS2_CLK),
    .level (clk_level),
    .fall  (clk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_sync_reg <= 2'b11;
    else     data_sync_reg <= {data_sync_reg[0], PS2_DATA};
  end
  assign data_sync = data_sync_reg[1];

  assign timer_next = (timer_reg == '1) ? timer_reg : timer_reg + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      timer_reg   <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
    end else begin
      timer_reg <= timer_next;
      case (state_reg)
        ST_IDLE: begin
          timer_reg <= '0;
          if (tx_valid) begin
            shift_reg   <= {~^tx_data, tx_data};
            bit_cnt_reg <= '0;
            clk_oe_reg  <= 1'b1;
            state_reg   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          // Start bit goes low one cycle before the clock is released.
          if (timer_reg == INH_DATA) data_oe_reg <= 1'b1;
          if (timer_reg == INH_LAST) begin
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b1;
            timer_reg   <= '0;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          if (timer_reg == START_LAST) begin
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            state_reg   <= ST_ERR;
          end else if (clk_fall) begin
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA, ST_STOP, ST_ACK, ST_WAIT_IDLE: begin
          if (timer_reg == XFER_LAST) begin
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            state_reg   <= ST_ERR;
          end else begin
            case (state_reg)
              ST_DATA: if (clk_fall) begin
                data_oe_reg <= ~shift_reg[0];
                shift_reg   <= {1'b0, shift_reg[8:1]};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == 4'd8) state_reg <= ST_STOP;
              end
              ST_STOP: if (clk_fall) begin
                data_oe_reg <= 1'b0;
                state_reg   <= ST_ACK;
              end
              ST_ACK: if (clk_fall) begin
                state_reg <= data_sync ? ST_ERR : ST_WAIT_IDLE;
              end
              default: if (clk_level && data_sync) state_reg <= ST_DONE;
            endcase
          end
        end
        default: begin
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign PS2_CLK  = clk_oe_reg  ? 1'b0 : 1'bz;
  assign PS2_DATA = data_oe_reg ? 1'b0 : 1'bz;

  assign tx_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg != ST_IDLE);
  assign tx_done  = (state_reg == ST_DONE);
  assign tx_error = (state_reg == ST_ERR);

endmodule
